decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// Instruction decode stage: register file with optional write-through bypass,
// immediate generation, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IF_VALID,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [XLEN-1:0] IF_PC_PLUS4,
    input  logic [31:0]     IF_INSTRUCTION,
    input  logic            STALL_IN,
    input  logic            FLUSH,
    input  logic            WB_WRITE_ENABLE,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_WRITE_DATA,
    output logic            IF_HOLD,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_PC_PLUS4,
    output logic [XLEN-1:0] ID_READ_DATA1,
    output logic [XLEN-1:0] ID_READ_DATA2,
    output logic [XLEN-1:0] ID_IMMEDIATE,
    output logic [4:0]      ID_RS1,
    output logic [4:0]      ID_RS2,
    output logic [4:0]      ID_RD,
    output logic [6:0]      ID_OPCODE,
    output logic [2:0]      ID_FUNC3,
    output logic [6:0]      ID_FUNC7,
    output logic            ID_MEM_READ
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // 32-bit sign-extended immediate for each instruction format
    function automatic logic [31:0] imm32(input logic [31:0] ins);
        logic [31:0] r;
        r = 32'd0;
        case (ins[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: r = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:  r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH: r = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: r = {ins[31:12], 12'h000};
            OPC_JAL:    r = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default:    r = 32'd0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] rf_r [NREGS];

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_f_s;
    logic [4:0]      rs2_f_s;
    logic [4:0]      rd_f_s;
    logic [AW-1:0]   rs1_idx_s;
    logic [AW-1:0]   rs2_idx_s;
    logic [AW-1:0]   wb_idx_s;
    logic            wb_en_s;
    logic            byp1_s;
    logic            byp2_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic [XLEN-1:0] imm_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            writes_rd_s;
    logic            load_use_s;

    assign opcode_s  = IF_INSTRUCTION[6:0];
    assign rd_f_s    = IF_INSTRUCTION[11:7];
    assign rs1_f_s   = IF_INSTRUCTION[19:15];
    assign rs2_f_s   = IF_INSTRUCTION[24:20];
    assign rs1_idx_s = IF_INSTRUCTION[15 +: AW];
    assign rs2_idx_s = IF_INSTRUCTION[20 +: AW];
    assign wb_idx_s  = WB_RD[AW-1:0];

    // Writes outside the implemented register range are dropped, x0 is never written
    assign wb_en_s = WB_WRITE_ENABLE && ({27'd0, WB_RD} < NREGS) && (WB_RD != 5'd0);

    assign byp1_s = (WB_BYPASS != 0) && WB_WRITE_ENABLE && (5'(rs1_idx_s) == WB_RD)
                    && (rs1_idx_s != '0);
    assign byp2_s = (WB_BYPASS != 0) && WB_WRITE_ENABLE && (5'(rs2_idx_s) == WB_RD)
                    && (rs2_idx_s != '0);

    // Register file storage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_en_s) begin
            rf_r[wb_idx_s] <= WB_WRITE_DATA;
        end
    end

    // Operand read ports with write-through bypass
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        if (rs1_idx_s == '0) begin
            rd1_s = '0;
        end else if (byp1_s) begin
            rd1_s = WB_WRITE_DATA;
        end else begin
            rd1_s = rf_r[rs1_idx_s];
        end
        if (rs2_idx_s == '0) begin
            rd2_s = '0;
        end else if (byp2_s) begin
            rd2_s = WB_WRITE_DATA;
        end else begin
            rd2_s = rf_r[rs2_idx_s];
        end
    end

    // Opcode classification and hazard detection
    always_comb begin
        imm_s       = XLEN'(signed'(imm32(IF_INSTRUCTION)));
        rs1_used_s  = !((opcode_s == OPC_LUI) || (opcode_s == OPC_AUIPC) || (opcode_s == OPC_JAL));
        rs2_used_s  = (opcode_s == OPC_OP) || (opcode_s == OPC_STORE) || (opcode_s == OPC_BRANCH);
        writes_rd_s = (opcode_s == OPC_LUI) || (opcode_s == OPC_AUIPC) || (opcode_s == OPC_JAL)
                   || (opcode_s == OPC_JALR) || (opcode_s == OPC_LOAD)
                   || (opcode_s == OPC_OPIMM) || (opcode_s == OPC_OP);
        load_use_s  = IF_VALID && ID_VALID && ID_MEM_READ && (ID_RD != 5'd0)
                   && ((rs1_used_s && (ID_RD == rs1_f_s)) || (rs2_used_s && (ID_RD == rs2_f_s)));
    end

    assign IF_HOLD = (STALL_IN || load_use_s) && !FLUSH;

    // ID/EX register: flush > stall > load-use bubble > load
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ID_VALID      <= 1'b0;
            ID_PC         <= '0;
            ID_PC_PLUS4   <= '0;
            ID_READ_DATA1 <= '0;
            ID_READ_DATA2 <= '0;
            ID_IMMEDIATE  <= '0;
            ID_RS1        <= 5'd0;
            ID_RS2        <= 5'd0;
            ID_RD         <= 5'd0;
            ID_OPCODE     <= 7'd0;
            ID_FUNC3      <= 3'd0;
            ID_FUNC7      <= 7'd0;
            ID_MEM_READ   <= 1'b0;
        end else if (FLUSH) begin
            ID_VALID      <= 1'b0;
            ID_PC         <= '0;
            ID_PC_PLUS4   <= '0;
            ID_READ_DATA1 <= '0;
            ID_READ_DATA2 <= '0;
            ID_IMMEDIATE  <= '0;
            ID_RS1        <= 5'd0;
            ID_RS2        <= 5'd0;
            ID_RD         <= 5'd0;
            ID_OPCODE     <= 7'd0;
            ID_FUNC3      <= 3'd0;
            ID_FUNC7      <= 7'd0;
            ID_MEM_READ   <= 1'b0;
        end else if (STALL_IN) begin
            ID_VALID      <= ID_VALID;
        end else if (load_use_s) begin
            ID_VALID      <= 1'b0;
            ID_RD         <= 5'd0;
            ID_MEM_READ   <= 1'b0;
        end else begin
            ID_VALID      <= IF_VALID;
            ID_PC         <= IF_PC;
            ID_PC_PLUS4   <= IF_PC_PLUS4;
            ID_READ_DATA1 <= rd1_s;
            ID_READ_DATA2 <= rd2_s;
            ID_IMMEDIATE  <= imm_s;
            ID_RS1        <= rs1_f_s;
            ID_RS2        <= rs2_f_s;
            ID_RD         <= writes_rd_s ? rd_f_s : 5'd0;
            ID_OPCODE     <= opcode_s;
            ID_FUNC3      <= IF_INSTRUCTION[14:12];
            ID_FUNC7      <= IF_INSTRUCTION[31:25];
            ID_MEM_READ   <= (opcode_s == OPC_LOAD);
        end
    end

endmodule
